fifo_write_arbiter: RTL and testbench

Shares the write port of a single-clock FIFO between `NUM_PORTS` producers using round-robin arbitration with packet locking. It sits between the producer blocks and the FIFO write side.
- Downstream port semantics: one word per `o_WrEnable` pulse; `o_WrEnable` must be low for at least one cycle between words.
- The block generates these pulses and enforces the gap.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // ARB accepts at most one word; WRITE presents that word to the FIFO for
  // exactly one cycle and then hands control back to ARB.
  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  // Increment a port index, wrapping from n-1 back to 0.
  function automatic int next_index(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or after the
// start pointer, wrapping past the top port back to port 0.
module rr_priority_pick #(
  parameter int NUM_PORTS   = 4,
  parameter int OWNER_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]   reqMask,
  input  logic [OWNER_WIDTH-1:0] startPtr,
  output logic                   found,
  output logic [OWNER_WIDTH-1:0] winner
);

  int                     rawIdx;
  logic [OWNER_WIDTH-1:0] selIdx;

  // Walk offsets from the farthest to the nearest so the nearest requester
  // is the last one written and therefore wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rawIdx = 0;
    selIdx = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      rawIdx = int'(startPtr) + off;
      if (rawIdx >= NUM_PORTS) begin
        rawIdx = rawIdx - NUM_PORTS;
      end
      selIdx = OWNER_WIDTH'(rawIdx);
      if (reqMask[selIdx]) begin
        found  = 1'b1;
        winner = selIdx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with packet locking that shares one FIFO write port
// between NUM_PORTS producers. Each accepted word becomes a single-cycle
// registered write pulse, so o_WrEnable is always low between words.
//
// Handshake: a producer holds i_ReqValid, i_ReqData and i_ReqLast stable
// until it sees o_ReqReady high in the same cycle; a word transfers on the
// rising edge where valid and ready are both high. Ready is combinational,
// only ever raised in ARB, one-hot, and forced low while i_Reset is high so
// a reset edge never swallows a word the producer believes was taken.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int NUM_PORTS   = 4,
  localparam int OWNER_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic [NUM_PORTS-1:0]            i_ReqValid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_ReqData,
  input  logic [NUM_PORTS-1:0]            i_ReqLast,
  output logic [NUM_PORTS-1:0]            o_ReqReady,
  input  logic                            i_CanWrite,
  output logic [DATA_WIDTH-1:0]           o_WrData,
  output logic                            o_WrEnable,
  output logic [OWNER_WIDTH-1:0]          o_Owner,
  output logic                            o_Locked,
  output logic                            o_DebugState,
  output logic [OWNER_WIDTH-1:0]          o_DebugPtr
);

  arb_state_t             state;
  arb_state_t             nextState;
  logic [OWNER_WIDTH-1:0] ptr;
  logic [NUM_PORTS-1:0]   ownerMask;
  logic [NUM_PORTS-1:0]   candMask;
  logic                   pickFound;
  logic [OWNER_WIDTH-1:0] pickWinner;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  portData [NUM_PORTS];

  // Split the flat data bus into one word per port for indexed selection.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      portData[p] = i_ReqData[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // While a packet is open only the current owner may compete.
  assign ownerMask = NUM_PORTS'(1) << o_Owner;
  assign candMask  = o_Locked ? (i_ReqValid & ownerMask) : i_ReqValid;

  rr_priority_pick #(
    .NUM_PORTS   (NUM_PORTS),
    .OWNER_WIDTH (OWNER_WIDTH)
  ) u_pick (
    .reqMask  (candMask),
    .startPtr (ptr),
    .found    (pickFound),
    .winner   (pickWinner)
  );

  // Next-state and ready decode; acceptance needs a candidate, room in the
  // FIFO and no reset pending on this edge.
  always_comb begin
    nextState  = state;
    accept     = 1'b0;
    o_ReqReady = '0;
    case (state)
      ARB: begin
        if (pickFound && i_CanWrite && !i_Reset) begin
          accept                 = 1'b1;
          o_ReqReady[pickWinner] = 1'b1;
          nextState              = WRITE;
        end
      end
      WRITE: begin
        nextState = ARB;
      end
      default: begin
        nextState = ARB;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= ARB;
    end else begin
      state <= nextState;
    end
  end

  // Capture the accepted word, owner and lock; advance the pointer only when
  // a packet closes so a locked packet never moves the rotation.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_WrEnable <= 1'b0;
      o_WrData   <= '0;
      o_Owner    <= '0;
      o_Locked   <= 1'b0;
      ptr        <= '0;
    end else begin
      o_WrEnable <= accept;
      if (accept) begin
        o_WrData <= portData[pickWinner];
        o_Owner  <= pickWinner;
        o_Locked <= ~i_ReqLast[pickWinner];
        if (i_ReqLast[pickWinner]) begin
          ptr <= OWNER_WIDTH'(next_index(int'(pickWinner), NUM_PORTS));
        end
      end
    end
  end

  assign o_DebugState = state;
  assign o_DebugPtr   = ptr;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queued producers, a cycle-level reference
// model derived from the arbitration rules, an expected-word scoreboard and
// directed scenarios followed by randomized traffic.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int OW = 2;
  localparam int QD = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_Reset;
  logic [NP-1:0]    valid;
  logic [NP*DW-1:0] data;
  logic [NP-1:0]    last;
  logic [NP-1:0]    o_ReqReady;
  logic             can_write;
  logic [DW-1:0]    o_WrData;
  logic             o_WrEnable;
  logic [OW-1:0]    o_Owner;
  logic             o_Locked;
  logic             o_DebugState;
  logic [OW-1:0]    o_DebugPtr;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .i_Clock      (clk),
    .i_Reset      (i_Reset),
    .i_ReqValid   (valid),
    .i_ReqData    (data),
    .i_ReqLast    (last),
    .o_ReqReady   (o_ReqReady),
    .i_CanWrite   (can_write),
    .o_WrData     (o_WrData),
    .o_WrEnable   (o_WrEnable),
    .o_Owner      (o_Owner),
    .o_Locked     (o_Locked),
    .o_DebugState (o_DebugState),
    .o_DebugPtr   (o_DebugPtr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- producer queues / driver ----------------
  logic [DW-1:0] pmem_d [NP][QD];
  logic          pmem_l [NP][QD];
  int            head [NP] = '{default: 0};
  int            tail [NP] = '{default: 0};
  logic [NP-1:0] acc_cap = '0;

  task automatic push_word(input int p, input logic [DW-1:0] d, input logic l);
    if (tail[p] < QD) begin
      pmem_d[p][tail[p]] = d;
      pmem_l[p][tail[p]] = l;
      tail[p]++;
    end
  endtask

  // Retire accepted words after each edge and present the next queued word.
  initial begin
    valid = '0;
    data  = '0;
    last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc_cap[p]) head[p]++;
        if (head[p] < tail[p]) begin
          valid[p]           = 1'b1;
          data[p*DW +: DW]   = pmem_d[p][head[p]];
          last[p]            = pmem_l[p][head[p]];
        end else begin
          valid[p] = 1'b0;
          last[p]  = 1'b0;
        end
      end
      @(negedge clk);
      #2;
      acc_cap = o_ReqReady & valid;
    end
  end

  // ---------------- reference model + compare ----------------
  int            m_ptr = 0, m_owner = 0, m_win = 0;
  bit            m_locked = 0, m_wr_en = 0, m_acc = 0, m_wlast = 0;
  logic [DW-1:0] m_wr_data = '0, m_wdata = '0;
  logic [15:0]   exp_q [$];
  int            grant_log [$];
  int            data_log [$];
  bit            lock_log [$];
  int            pulse_cyc [$];

  initial begin
    logic [NP-1:0] cand;
    logic [NP-1:0] exp_ready;
    logic [15:0]   e;
    int            idx;
    forever begin
      @(posedge clk);
      if (i_Reset) begin
        m_ptr = 0; m_owner = 0; m_locked = 0; m_wr_en = 0; m_wr_data = '0;
      end else begin
        m_wr_en = m_acc;
        if (m_acc) begin
          m_wr_data = m_wdata;
          m_owner   = m_win;
          m_locked  = !m_wlast;
          if (m_wlast) m_ptr = (m_win + 1) % NP;
          exp_q.push_back({8'(m_win), m_wdata});
        end
      end
      @(negedge clk);
      #3;
      cyc++;
      cand = m_locked ? (valid & (NP'(1) << m_owner)) : valid;
      m_acc = 0;
      m_win = 0;
      if (!m_wr_en && can_write && !i_Reset) begin
        for (int k = 0; k < NP; k++) begin
          idx = (m_ptr + k) % NP;
          if (!m_acc && cand[idx]) begin
            m_acc = 1;
            m_win = idx;
          end
        end
      end
      exp_ready = m_acc ? (NP'(1) << m_win) : '0;
      if (m_acc) begin
        m_wdata = data[m_win*DW +: DW];
        m_wlast = last[m_win];
      end
      check("ready",   o_ReqReady, exp_ready);
      check("wr_en",   o_WrEnable, m_wr_en);
      check("wr_data", o_WrData,   m_wr_data);
      check("owner",   o_Owner,    m_owner);
      check("locked",  o_Locked,   m_locked);
      check("state",   o_DebugState, m_wr_en ? WRITE : ARB);
      check("ptr",     o_DebugPtr, m_ptr);
      if (o_WrEnable === 1'b1) begin
        grant_log.push_back(int'(o_Owner));
        data_log.push_back(int'(o_WrData));
        lock_log.push_back(o_Locked);
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          timeout("sb_unexpected_write");
        end else begin
          e = exp_q.pop_front();
          check("sb_data",  o_WrData, e[7:0]);
          check("sb_owner", o_Owner,  e[15:8]);
        end
      end
    end
  end

  // ---------------- helpers for the directed sequence ----------------
  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    data_log.delete();
    lock_log.delete();
    pulse_cyc.delete();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int b;
    b = 0;
    while (pulse_cyc.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (pulse_cyc.size() < n) timeout("wait_pulses");
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int b = 0; b < budget && !done; b++) begin
      tick();
      done = (o_WrEnable === 1'b0) && (exp_q.size() == 0);
      for (int p = 0; p < NP; p++) if (head[p] != tail[p]) done = 0;
    end
    if (!done) timeout("wait_idle");
  endtask

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int exp_g2 [5] = '{0, 1, 2, 3, 0};
    int exp_d2 [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h14};
    int exp_g3 [4] = '{2, 2, 2, 0};
    bit exp_l3 [4] = '{1, 1, 0, 0};
    int exp_g5 [5] = '{3, 3, 3, 0, 1};
    int len;
    i_Reset   = 1'b1;
    can_write = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_Reset = 1'b0;

    // Idle after reset: everything stays at reset values.
    repeat (10) tick();
    check("rst_wr_en",   o_WrEnable, 0);
    check("rst_wr_data", o_WrData,   0);
    check("rst_owner",   o_Owner,    0);
    check("rst_locked",  o_Locked,   0);
    check("rst_ready",   o_ReqReady, 0);
    check("rst_state",   o_DebugState, ARB);
    check("rst_pulses",  pulse_cyc.size(), 0);

    // Single-word requests from every port rotate 0,1,2,3,0.
    clear_logs();
    push_word(0, 8'h10, 1); push_word(1, 8'h21, 1);
    push_word(2, 8'h32, 1); push_word(3, 8'h43, 1);
    push_word(0, 8'h14, 1);
    wait_pulses(5, 40);
    for (int i = 0; i < 5; i++) begin
      check("rr_grant", log_at(i), exp_g2[i]);
      check("rr_data", (i < data_log.size()) ? data_log[i] : -1, exp_d2[i]);
    end
    for (int i = 0; i + 1 < pulse_cyc.size() && i < 4; i++)
      check("rr_cadence", pulse_cyc[i+1] - pulse_cyc[i], 2);
    wait_idle(40);

    // A 3-word packet from port 2 holds off port 0 until it closes.
    clear_logs();
    push_word(2, 8'hA1, 0); push_word(2, 8'hA2, 0); push_word(2, 8'hA3, 1);
    push_word(0, 8'h05, 1);
    wait_pulses(4, 40);
    for (int i = 0; i < 4; i++) begin
      check("pkt_grant", log_at(i), exp_g3[i]);
      check("pkt_lock", (i < lock_log.size()) ? lock_log[i] : 1'bx, exp_l3[i]);
    end
    wait_idle(40);

    // FIFO full blocks acceptance; release gives ready then a pulse.
    clear_logs();
    at_edge();
    can_write = 1'b0;
    push_word(1, 8'h5A, 1);
    repeat (5) begin
      tick();
      check("full_ready", o_ReqReady, 0);
      check("full_wr_en", o_WrEnable, 0);
    end
    at_edge();
    can_write = 1'b1;
    tick();
    check("cw_ready", o_ReqReady, 4'b0010);
    check("cw_wr_en", o_WrEnable, 0);
    tick();
    check("cw_pulse", o_WrEnable, 1);
    check("cw_data",  o_WrData,   8'h5A);
    wait_idle(40);

    // Locked owner 3 runs dry; ports 0 and 1 must starve until it resumes.
    clear_logs();
    push_word(3, 8'h30, 0); push_word(3, 8'h31, 0);
    push_word(0, 8'h0A, 1); push_word(1, 8'h1B, 1);
    wait_pulses(2, 40);
    repeat (4) begin
      tick();
      check("starve_wr_en", o_WrEnable, 0);
      check("starve_lock",  o_Locked,   1);
      check("starve_owner", o_Owner,    3);
      check("starve_ready", o_ReqReady, 0);
    end
    check("starve_pulses", pulse_cyc.size(), 2);
    at_edge();
    push_word(3, 8'h32, 1);
    wait_pulses(5, 40);
    for (int i = 0; i < 5; i++) check("starve_grant", log_at(i), exp_g5[i]);
    wait_idle(40);

    // Reset during a mid-packet write drops the lock and the pointer.
    clear_logs();
    push_word(2, 8'hC1, 0); push_word(2, 8'hC2, 0); push_word(2, 8'hC3, 1);
    push_word(0, 8'h0C, 1);
    wait_pulses(1, 40);
    check("mid_owner", o_Owner,  2);
    check("mid_lock",  o_Locked, 1);
    i_Reset = 1'b1;
    tick();
    check("mrst_wr_en", o_WrEnable, 0);
    check("mrst_lock",  o_Locked,   0);
    check("mrst_ptr",   o_DebugPtr, 0);
    check("mrst_ready", o_ReqReady, 0);
    at_edge();
    i_Reset = 1'b0;
    wait_pulses(2, 40);
    check("mrst_first", log_at(1), 0);
    wait_idle(60);

    // Randomized traffic, back-pressure and occasional resets.
    repeat (1500) begin
      at_edge();
      can_write = ($urandom_range(0, 3) != 0);
      i_Reset   = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NP; p++) begin
        if ((tail[p] - head[p]) < 2 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int w = 0; w < len; w++)
            push_word(p, 8'($urandom_range(0, 255)), (w == len - 1));
        end
      end
    end
    at_edge();
    i_Reset   = 1'b0;
    can_write = 1'b1;
    wait_idle(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
